// File: rtl/csi_tx_packet_builder.sv
// ============================================================================
// csi_tx_packet_builder: CSI-2 transmit packet framer for a 2-lane D-PHY link.
// Revision: 1.0
// ============================================================================
`default_nettype none

module csi_tx_packet_builder #(
  parameter logic [1:0] VC             = 2'b00,
  parameter logic [5:0] FS_DT          = 6'h00,
  parameter logic [5:0] FE_DT          = 6'h01,
  parameter logic [5:0] VIDEO_DT       = 6'h2A,
  parameter int         HS_PREP_CYCLES = 4,
  parameter int         TRAIL_CYCLES   = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_type,
  input  logic [15:0] cmd_len,
  output logic        cmd_ready,
  input  logic [31:0] payload_data,
  input  logic        payload_valid,
  output logic        payload_ready,
  output logic        hs_request,
  output logic [15:0] lane_bytes,
  output logic        lane_valid,
  output logic        underflow,
  output logic        busy
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_PREP    = 3'd1;
  localparam logic [2:0] S_SYNC    = 3'd2;
  localparam logic [2:0] S_HDR0    = 3'd3;
  localparam logic [2:0] S_HDR1    = 3'd4;
  localparam logic [2:0] S_PAYLOAD = 3'd5;
  localparam logic [2:0] S_CRC     = 3'd6;
  localparam logic [2:0] S_TRAIL   = 3'd7;

  localparam logic [1:0] T_FS   = 2'd0;
  localparam logic [1:0] T_FE   = 2'd1;
  localparam logic [1:0] T_LINE = 2'd2;
  localparam logic [1:0] T_NOP  = 2'd3;

  localparam logic [7:0] PREP_LOAD  = 8'(HS_PREP_CYCLES - 1);
  localparam logic [7:0] TRAIL_LOAD = 8'(TRAIL_CYCLES - 1);

  function automatic logic [7:0] ecc_calc(input logic [23:0] d);
    logic [7:0] p;
    p    = 8'h00;
    p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
    p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
    p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
    p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
    p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
    p[5] = (^d[19:10])^d[21]^d[22]^d[23];
    return p;
  endfunction

  // Reflected CRC-16-CCITT (poly 0x8408), one byte, LSB first.
  function automatic logic [15:0] crc_byte(input logic [15:0] c, input logic [7:0] b);
    logic [15:0] r;
    r = c ^ {8'h00, b};
    for (int i = 0; i < 8; i++) begin
      r = r[0] ? ((r >> 1) ^ 16'h8408) : (r >> 1);
    end
    return r;
  endfunction

  logic [2:0]  state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [14:0] beats_q, beats_d;
  logic        phase_q, phase_d;
  logic [1:0]  type_q, type_d;
  logic [15:0] wc_q, wc_d;
  logic [15:0] frame_num_q, frame_num_d;
  logic [15:0] crc_q, crc_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] lane_bytes_q, lane_bytes_d;
  logic        hs_request_q, hs_request_d;
  logic        lane_valid_q, lane_valid_d;
  logic        payload_ready_q, payload_ready_d;
  logic        underflow_q, underflow_d;
  logic        busy_q, busy_d;
  logic        cmd_ready_q, cmd_ready_d;

  logic [5:0]  dt_sel;
  logic [7:0]  di;
  logic [7:0]  ecc;
  logic [15:0] word;
  logic        unused_len_bits;

  assign unused_len_bits = ^cmd_len[1:0];
  assign di  = {VC, dt_sel};
  assign ecc = ecc_calc({wc_q, di});

  always_comb begin
    case (type_q)
      T_FS:    dt_sel = FS_DT;
      T_FE:    dt_sel = FE_DT;
      default: dt_sel = VIDEO_DT;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    beats_d     = beats_q;
    phase_d     = phase_q;
    type_d      = type_q;
    wc_d        = wc_q;
    frame_num_d = frame_num_q;
    crc_d       = crc_q;
    hold_d      = hold_q;
    underflow_d = 1'b0;
    word        = 16'h0000;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready_q && (cmd_type != T_NOP)) begin
          state_d = S_PREP;
          cnt_d   = PREP_LOAD;
          type_d  = cmd_type;
          wc_d    = (cmd_type == T_LINE) ? {cmd_len[15:2], 2'b00} : frame_num_q;
          crc_d   = 16'hFFFF;
        end
      end
      S_PREP: begin
        if (cnt_q == 8'd0) state_d = S_SYNC;
        else               cnt_d   = cnt_q - 8'd1;
      end
      S_SYNC: state_d = S_HDR0;
      S_HDR0: state_d = S_HDR1;
      S_HDR1: begin
        if (type_q == T_LINE) begin
          if (wc_q != 16'h0000) begin
            state_d = S_PAYLOAD;
            beats_d = wc_q[15:1];
            phase_d = 1'b0;
          end else begin
            state_d = S_CRC;
          end
        end else begin
          state_d = S_TRAIL;
          cnt_d   = TRAIL_LOAD;
        end
      end
      S_PAYLOAD: begin
        beats_d = beats_q - 15'd1;
        phase_d = ~phase_q;
        if (beats_q == 15'd1) state_d = S_CRC;
      end
      S_CRC: begin
        state_d = S_TRAIL;
        cnt_d   = TRAIL_LOAD;
      end
      default: begin
        if (cnt_q == 8'd0) begin
          state_d = S_IDLE;
          if (type_q == T_FE)
            frame_num_d = (frame_num_q == 16'hFFFF) ? 16'h0001 : frame_num_q + 16'd1;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
    endcase

    // Outputs are computed for the cycle that state_d describes, then registered.
    case (state_d)
      S_SYNC:    lane_bytes_d = 16'hB8B8;
      S_HDR0:    lane_bytes_d = {wc_q[7:0], di};
      S_HDR1:    lane_bytes_d = {ecc, wc_q[15:8]};
      S_PAYLOAD: begin
        if (!phase_d) begin
          if (payload_ready_q && payload_valid) begin
            word   = payload_data[15:0];
            hold_d = payload_data[31:16];
          end else begin
            hold_d      = 16'h0000;
            underflow_d = 1'b1;
          end
        end else begin
          word = hold_q;
        end
        lane_bytes_d = word;
        crc_d        = crc_byte(crc_byte(crc_q, word[7:0]), word[15:8]);
      end
      S_CRC:     lane_bytes_d = crc_q;
      S_TRAIL:   lane_bytes_d = (state_q == S_TRAIL) ? lane_bytes_q : ~lane_bytes_q;
      default:   lane_bytes_d = 16'h0000;
    endcase

    hs_request_d    = (state_d != S_IDLE);
    busy_d          = (state_d != S_IDLE);
    cmd_ready_d     = (state_d == S_IDLE);
    lane_valid_d    = (state_d >= S_SYNC) && (state_d <= S_CRC);
    // Fetch a word one cycle ahead of each phase-0 payload cycle.
    payload_ready_d = ((state_d == S_HDR1) && (type_q == T_LINE) && (wc_q != 16'h0000)) ||
                      ((state_d == S_PAYLOAD) && phase_d && (beats_d > 15'd1));
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_IDLE;
      cnt_q           <= 8'd0;
      beats_q         <= 15'd0;
      phase_q         <= 1'b0;
      type_q          <= T_FS;
      wc_q            <= 16'h0000;
      frame_num_q     <= 16'h0001;
      crc_q           <= 16'h0000;
      hold_q          <= 16'h0000;
      lane_bytes_q    <= 16'h0000;
      hs_request_q    <= 1'b0;
      lane_valid_q    <= 1'b0;
      payload_ready_q <= 1'b0;
      underflow_q     <= 1'b0;
      busy_q          <= 1'b0;
      cmd_ready_q     <= 1'b0;
    end else begin
      state_q         <= state_d;
      cnt_q           <= cnt_d;
      beats_q         <= beats_d;
      phase_q         <= phase_d;
      type_q          <= type_d;
      wc_q            <= wc_d;
      frame_num_q     <= frame_num_d;
      crc_q           <= crc_d;
      hold_q          <= hold_d;
      lane_bytes_q    <= lane_bytes_d;
      hs_request_q    <= hs_request_d;
      lane_valid_q    <= lane_valid_d;
      payload_ready_q <= payload_ready_d;
      underflow_q     <= underflow_d;
      busy_q          <= busy_d;
      cmd_ready_q     <= cmd_ready_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign payload_ready = payload_ready_q;
  assign hs_request    = hs_request_q;
  assign lane_bytes    = lane_bytes_q;
  assign lane_valid    = lane_valid_q;
  assign underflow     = underflow_q;
  assign busy          = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_csi_tx_packet_builder.sv
// Testbench for csi_tx_packet_builder: directed and random packets checked
// cycle by cycle against a packet-level reference model.
`default_nettype none

module tb_csi_tx_packet_builder;

  localparam int PREP  = 4;
  localparam int TRAIL = 2;
  localparam logic [23:0] ECC_MASK [6] = '{24'hF12CB7, 24'hF2555B, 24'h749A6D,
                                           24'hB8E38E, 24'hDF03F0, 24'hEFFC00};

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic [1:0]  cmd_type = 2'd3;
  logic [15:0] cmd_len = 16'h0;
  logic        cmd_ready;
  logic [31:0] payload_data = 32'h0;
  logic        payload_valid = 1'b0;
  logic        payload_ready;
  logic        hs_request;
  logic [15:0] lane_bytes;
  logic        lane_valid;
  logic        underflow;
  logic        busy;

  csi_tx_packet_builder dut (
    .clock(clock), .reset(reset),
    .cmd_valid(cmd_valid), .cmd_type(cmd_type), .cmd_len(cmd_len), .cmd_ready(cmd_ready),
    .payload_data(payload_data), .payload_valid(payload_valid), .payload_ready(payload_ready),
    .hs_request(hs_request), .lane_bytes(lane_bytes), .lane_valid(lane_valid),
    .underflow(underflow), .busy(busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int failures = 0;
  int pkt_id = 0;
  logic [15:0] model_frame = 16'h0001;
  logic [31:0] words[$];
  bit          vflags[$];

  logic [21:0] obs;
  assign obs = {hs_request, lane_valid, lane_bytes, payload_ready, underflow, busy, cmd_ready};

  function automatic logic [21:0] pack(logic hs, logic lv, logic [15:0] ln,
                                       logic pr, logic uf, logic bz, logic cr);
    return {hs, lv, ln, pr, uf, bz, cr};
  endfunction

  function automatic logic [7:0] ecc_model(logic [23:0] d);
    logic [7:0] e = 8'h00;
    for (int k = 0; k < 6; k++) e[k] = ^(d & ECC_MASK[k]);
    return e;
  endfunction

  function automatic logic [15:0] crc_model(logic [15:0] c, logic [7:0] b);
    logic [15:0] r = c;
    for (int i = 0; i < 8; i++) begin
      logic fb;
      fb = r[0] ^ b[i];
      r  = r >> 1;
      if (fb) r = r ^ 16'h8408;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [21:0] o, input logic [21:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic wait_ready();
    int n = 0;
    while (cmd_ready !== 1'b1 && n < 60) begin
      @(negedge clock);
      n++;
    end
    if (n >= 60) chk("cmd_ready_timeout", {21'h0, cmd_ready}, 22'h1);
  endtask

  // Builds the full expected observation sequence of one packet, issues the
  // command, and feeds payload words exactly when the word must be fetched.
  task automatic do_packet(input logic [1:0] typ, input logic [15:0] len);
    logic [21:0] exp[$];
    logic [15:0] wc, crc, last, lanes;
    logic [7:0]  di;
    logic [31:0] w;
    int nwords, j;
    wc = (typ == 2'd2) ? {len[15:2], 2'b00} : model_frame;
    di = (typ == 2'd0) ? 8'h00 : (typ == 2'd1) ? 8'h01 : 8'h2A;
    nwords = (typ == 2'd2) ? int'(wc) / 4 : 0;
    while (words.size() < nwords) words.push_back($urandom);
    while (vflags.size() < nwords) vflags.push_back(1'b1);

    for (int k = 0; k < PREP; k++) exp.push_back(pack(1, 0, 16'h0, 0, 0, 1, 0));
    exp.push_back(pack(1, 1, 16'hB8B8, 0, 0, 1, 0));
    exp.push_back(pack(1, 1, {wc[7:0], di}, 0, 0, 1, 0));
    lanes = {ecc_model({wc, di}), wc[15:8]};
    exp.push_back(pack(1, 1, lanes, nwords > 0, 0, 1, 0));
    last = lanes;
    crc  = 16'hFFFF;
    for (int k = 0; k < nwords; k++) begin
      w = vflags[k] ? words[k] : 32'h0;
      for (int b = 0; b < 4; b++) crc = crc_model(crc, w[8*b +: 8]);
      exp.push_back(pack(1, 1, w[15:0], 0, !vflags[k], 1, 0));
      exp.push_back(pack(1, 1, w[31:16], k < nwords - 1, 0, 1, 0));
    end
    if (typ == 2'd2) begin
      exp.push_back(pack(1, 1, crc, 0, 0, 1, 0));
      last = crc;
    end
    for (int k = 0; k < TRAIL; k++) exp.push_back(pack(1, 0, ~last, 0, 0, 1, 0));
    exp.push_back(pack(0, 0, 16'h0, 0, 0, 0, 1));

    wait_ready();
    cmd_valid = 1'b1;
    cmd_type  = typ;
    cmd_len   = len;
    j = 0;
    foreach (exp[k]) begin
      @(negedge clock);
      cmd_valid = 1'b0;
      cmd_type  = 2'($urandom);
      chk($sformatf("pkt%0d_t%0d_cyc%0d", pkt_id, typ, k), obs, exp[k]);
      if (exp[k][3] && j < nwords) begin
        payload_valid = vflags[j];
        payload_data  = words[j];
        j++;
      end else begin
        payload_valid = 1'($urandom);
        payload_data  = $urandom;
      end
    end
    if (typ == 2'd1) model_frame = (model_frame == 16'hFFFF) ? 16'h0001 : model_frame + 16'd1;
    words.delete();
    vflags.delete();
    pkt_id++;
  endtask

  task automatic do_noop();
    wait_ready();
    cmd_valid = 1'b1;
    cmd_type  = 2'd3;
    @(negedge clock);
    cmd_valid = 1'b0;
    chk("noop", obs, pack(0, 0, 16'h0, 0, 0, 0, 1));
  endtask

  initial begin
    int r;
    repeat (3) @(negedge clock);
    chk("reset_state", obs, 22'h0);
    reset = 1'b0;
    @(negedge clock);

    // Directed sequence.
    do_packet(2'd0, 16'h0);                 // FS, WC=1
    do_packet(2'd1, 16'h0);                 // FE, WC=1
    do_packet(2'd0, 16'h0);                 // FS, WC=2
    words.push_back(32'h34333231); vflags.push_back(1'b1);
    do_packet(2'd2, 16'd4);
    do_packet(2'd2, 16'd0);
    do_packet(2'd2, 16'd3);
    words.push_back($urandom); vflags.push_back(1'b1);
    words.push_back($urandom); vflags.push_back(1'b0);
    do_packet(2'd2, 16'd8);
    do_noop();

    // Random sequence.
    for (int i = 0; i < 25; i++) begin
      r = $urandom_range(0, 9);
      if (r < 2)       do_packet(2'd0, 16'($urandom));
      else if (r < 4)  do_packet(2'd1, 16'($urandom));
      else if (r == 4) do_noop();
      else begin
        int len = $urandom_range(0, 40);
        for (int k = 0; k < len / 4; k++) begin
          words.push_back($urandom);
          vflags.push_back($urandom_range(0, 4) != 0);
        end
        do_packet(2'd2, 16'(len));
      end
    end

    // Frame number wrap via backdoor.
    wait_ready();
    force dut.frame_num_q = 16'hFFFF;
    @(posedge clock);
    @(negedge clock);
    release dut.frame_num_q;
    model_frame = 16'hFFFF;
    do_packet(2'd0, 16'h0);
    do_packet(2'd1, 16'h0);
    do_packet(2'd0, 16'h0);

    // Reset in the middle of a payload.
    wait_ready();
    cmd_valid = 1'b1;
    cmd_type  = 2'd2;
    cmd_len   = 16'd16;
    payload_valid = 1'b1;
    repeat (PREP + 6) begin
      @(negedge clock);
      cmd_valid = 1'b0;
    end
    chk("mid_payload_busy", {21'h0, busy}, 22'h1);
    reset = 1'b1;
    @(negedge clock);
    chk("reset_abort", obs, 22'h0);
    reset = 1'b0;
    payload_valid = 1'b0;
    model_frame = 16'h0001;
    @(negedge clock);
    do_packet(2'd0, 16'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/csi_tx_packet_builder.md
# csi_tx_packet_builder

Transmit-side CSI-2 link block for 2-lane D-PHY output, running on the byte/word clock. It accepts frame-start, frame-end and line commands plus a 32-bit payload stream. It emits per-lane HS byte streams, each packet framed as: HS request, sync byte, ECC-protected header, payload, CRC-16 footer and HS trail. Downstream serialisers consume lane_bytes; upstream pixel logic feeds commands and payload words.

## Interface
- VC, 2'b00, virtual channel placed in DI[7:6]
- FS_DT, 6'h00, frame start data type
- FE_DT, 6'h01, frame end data type
- VIDEO_DT, 6'h2A, long-packet data type
- HS_PREP_CYCLES, 4, cycles with hs_request=1 before the sync byte (≥1)
- TRAIL_CYCLES, 2, cycles of HS trail after the last byte (≥1)

Ports:
- clock  in  1  word clock, all logic on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command present
- cmd_type  in  2  0=FS, 1=FE, 2=line, 3=no-op
- cmd_len  in  16  line payload length in bytes; bits [1:0] ignored
- cmd_ready  out  1  high only in IDLE and not in reset
- payload_data  in  32  byte0=[7:0] … byte3=[31:24]
- payload_valid  in  1  word available
- payload_ready  out  1  word consumed this cycle when valid
- hs_request  out  1  lanes must be in HS mode
- lane_bytes  out  16  lane0=[7:0], lane1=[15:8]
- lane_valid  out  1  lane_bytes carry packet bytes
- underflow  out  1  one-cycle pulse: payload word needed but payload_valid low
- busy  out  1  state != IDLE

## Operation
- States: IDLE → PREP → SYNC → HDR0 → HDR1 → (PAYLOAD → CRC, line only) → TRAIL → IDLE.
- A command is accepted when cmd_valid && cmd_ready. A no-op is accepted with no state change.
- Packet byte k goes to lane k%2. Each cycle carries bytes 2n on lane0 and 2n+1 on lane1.
- SYNC: both lanes 8'hB8.
- Header bytes: DI={VC,DT}, WC[7:0], WC[15:8], ECC.
  - HDR0 = {WC[7:0], DI}.
  - HDR1 = {ECC, WC[15:8]}.
- Short packets carry frame_num as WC.
  - frame_num resets to 16'h0001.
  - It increments after each FE packet completes and wraps 16'hFFFF→16'h0001, never 0.
- Line WC = {cmd_len[15:2],2'b00}.
- ECC over D[23:0]={WC hi, WC lo, DI}:
  - P0=D0^1^2^4^5^7^10^11^13^16^20^21^22^23
  - P1=D0^1^3^4^6^8^10^12^14^17^20^21^22^23
  - P2=D0^2^3^5^6^9^11^12^15^18^20^21^22
  - P3=D1^2^3^7^8^9^13^14^15^19^20^21^23
  - P4=D4^5^6^7^8^9^16^17^18^19^20^22^23
  - P5=D10^…^19^21^22^23
  - ECC[7:6]=0
- PAYLOAD takes WC/2 cycles, alternating phase 0/1. If WC=0, it goes straight to CRC.
  - Phase 0: payload_ready=1. Emits payload_data[15:0] and latches [31:16].
  - Phase 0 with payload_valid=0: emits 16'h0000, latches 0, pulses underflow. Byte count and CRC still advance on the zeros.
  - Phase 1: emits the latched half; payload_ready=0.
- CRC:
  - Algorithm: CRC-16-CCITT, reflected poly 16'h8408, init 16'hFFFF, no final XOR, over payload bytes in order. Two bytes are folded per cycle.
  - Footer: lane0=crc[7:0], lane1=crc[15:8].
  - Empty payload → 16'hFFFF.
- TRAIL: lane_valid=0, hs_request=1. Each lane drives the bitwise complement of its last valid byte.
- Outside PREP..TRAIL: hs_request=0, lane_valid=0, lane_bytes=0.
- Reset mid-packet aborts immediately. On the next edge all outputs return to reset values, state=IDLE, frame_num=1, CRC cleared.
- Reset values: hs_request=0, lane_valid=0, lane_bytes=0, payload_ready=0, underflow=0, busy=0, cmd_ready=0 while reset high.

## Timing
- Command accepted at edge T.
  - hs_request rises at T+1.
  - SYNC is at T+HS_PREP_CYCLES+1.
  - HDR0/HDR1 follow on the next two cycles.
- First payload cycle is T+HS_PREP_CYCLES+4. The CRC cycle immediately follows the last payload cycle.
- hs_request is high for exactly HS_PREP_CYCLES+3+TRAIL_CYCLES cycles for short packets. For lines it is high for HS_PREP_CYCLES+4+WC/2+TRAIL_CYCLES cycles.
- cmd_ready is high the cycle after the last TRAIL cycle. Back-to-back commands produce one IDLE cycle between packets.
- All outputs are registered. payload_ready is decoded from registered state only; there is no combinational path from payload_valid.

## Test plan
- FS after reset, defaults: lane0/lane1 sequence B8/B8, 00/01, 00/1A, then 2 trail cycles FF/E5. hs_request high 9 cycles.
- FE after that FS: header 01/01, 00/1D. frame_num becomes 2. A following FS carries WC=0x0002.
- Line cmd_len=4, payload 32'h34333231: header 2A/04, 00/33; payload 31/32 then 33/34; footer matches the CRC-16/MCRF4XX model (model check: "123456789"→0x6F91). payload_ready is a single pulse.
- Line cmd_len=0 (and cmd_len=3): WC=0, no payload cycles, footer FF/FF, no payload_ready.
- Line cmd_len=8 with payload_valid low on the second word: two underflow-free cycles, then underflow pulse. Lanes emit 00/00, 00/00. CRC is computed over the zeros.
- Force frame_num=0xFFFF via 65534 FS/FE pairs (or a backdoor); the next FE wraps it to 0x0001. Assert reset during PAYLOAD: all outputs reach 0 on the next edge, and a later FS carries WC=0x0001.
